// File: rtl/registro_multipuerto.sv
// Multi-port register file: one write port, NR combinational read ports with optional
// same-cycle write forwarding, hard-wired zero register and a full-array clear sweep.
module registro_multipuerto #(
  parameter int N        = 5,
  parameter int W        = 8,
  parameter int NR       = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [N-1:0]    addr_rd,
  input  logic [W-1:0]    data_in,
  input  logic [NR*N-1:0] addr_rs,
  output logic [NR*W-1:0] rs,
  input  logic            clr,
  output logic            busy,
  output logic            wr_drop
);

  localparam int DEPTH = 1 << N;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   ptr_q, ptr_d;
  logic           wr_drop_q, wr_drop_d;
  logic [W-1:0]   mem_q [DEPTH];

  logic           accept_s;
  logic           drop_s;
  logic           mem_we_s;
  logic [N-1:0]   mem_waddr_s;
  logic [W-1:0]   mem_wdata_s;

  // Next-state, sweep pointer and write-port arbitration between user writes and the sweep
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    accept_s    = 1'b0;
    drop_s      = 1'b0;
    mem_we_s    = 1'b0;
    mem_waddr_s = addr_rd;
    mem_wdata_s = data_in;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
          drop_s  = we;
        end else begin
          accept_s = we;
          mem_we_s = we && !((ZERO_REG != 0) && (addr_rd == '0));
        end
      end
      ST_CLEAR: begin
        // The sweep owns the write port; clr is ignored so the sweep cannot restart.
        drop_s      = we;
        mem_we_s    = 1'b1;
        mem_waddr_s = ptr_q;
        mem_wdata_s = '0;
        ptr_d       = ptr_q + N'(1);
        if (ptr_q == {N{1'b1}}) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
    wr_drop_d = drop_s;
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Register array storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
    end else if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end else begin
      mem_q <= mem_q;
    end
  end

  // Read ports: zero register has priority, then forwarding of an accepted write
  always_comb begin
    rs = '0;
    for (int k = 0; k < NR; k++) begin
      if ((ZERO_REG != 0) && (addr_rs[k*N +: N] == '0)) begin
        rs[k*W +: W] = '0;
      end else if ((BYPASS != 0) && accept_s && (addr_rd == addr_rs[k*N +: N])) begin
        rs[k*W +: W] = data_in;
      end else begin
        rs[k*W +: W] = mem_q[addr_rs[k*N +: N]];
      end
    end
  end

  assign busy    = (state_q == ST_CLEAR);
  assign wr_drop = wr_drop_q;

endmodule

// File: doc/registro_multipuerto.md
REGISTRO_MULTIPUERTO -- requirements
Module: registro_multipuerto

Interface
REQ-001 SHALL have parameter N, default 5: address width; depth = 2**N registers.
REQ-002 SHALL have parameter W, default 8: register data width.
REQ-003 SHALL have parameter NR, default 2: number of read ports, legal range 1..8.
REQ-004 SHALL have parameter BYPASS, default 1: when 1, forward same-cycle write data to the read ports.
REQ-005 SHALL have parameter ZERO_REG, default 1: when 1, register 0 reads 0 and ignores writes.
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port we, input, 1: write enable.
REQ-009 SHALL have port addr_rd, input, N: write address.
REQ-010 SHALL have port data_in, input, W: write data.
REQ-011 SHALL have port addr_rs, input, NR*N: packed read addresses; port k uses bits [k*N +: N].
REQ-012 SHALL have port rs, output, NR*W: packed read data; port k uses bits [k*W +: W].
REQ-013 SHALL have port clr, input, 1: request a sweep clear of the whole array.
REQ-014 SHALL have port busy, output, 1: high while a clear sweep is in progress.
REQ-015 SHALL have port wr_drop, output, 1: registered one-cycle pulse marking a write request that was discarded.

Function
REQ-016 SHALL accept a write when we=1 and state=IDLE and clr=0; mem[addr_rd] <= data_in at that rising edge.
REQ-017 SHALL ignore an accepted write to address 0 when ZERO_REG=1, and SHALL NOT assert wr_drop for it.
REQ-018 SHALL drive each read port combinationally: rs[k] = mem[addr_rs[k]], with zero latency.
REQ-019 SHALL return 0 on any read port addressing register 0 when ZERO_REG=1, regardless of bypass.
REQ-020 SHALL drive rs[k] = data_in when BYPASS=1, the write is accepted this cycle, and addr_rd == addr_rs[k]; otherwise rs[k] returns stored contents.
REQ-021 SHALL allow all NR ports to read the same address simultaneously with identical results.
REQ-022 SHALL implement an FSM with states IDLE and CLEAR.
REQ-023 SHALL transition IDLE->CLEAR on a rising edge with clr=1, loading the sweep pointer with 0.
REQ-024 SHALL write 0 to mem[ptr] in each CLEAR cycle and increment ptr.
REQ-025 SHALL transition CLEAR->IDLE on the edge where ptr == 2**N-1 is cleared; the sweep lasts exactly 2**N cycles.
REQ-026 SHALL assert busy combinationally as state==CLEAR; busy SHALL rise the cycle after clr is sampled.
REQ-027 SHALL ignore clr while in CLEAR; the sweep SHALL NOT restart or extend.
REQ-028 SHALL discard a write requested with we=1 in CLEAR, or with we=1 and clr=1 in IDLE, and SHALL pulse wr_drop high in the following cycle.
REQ-029 SHALL disable bypass for a discarded write; reads during CLEAR return current array contents, which may be a mix of old values and zeros.
REQ-030 SHALL make the sweep pointer wrap-free: ptr width N, terminal compare at all-ones, with no out-of-range access.

Reset
REQ-031 SHALL, on rst=0 asynchronously, clear every mem entry to 0, force state=IDLE, ptr=0, and wr_drop=0.
REQ-032 SHALL abort an in-progress sweep on reset and leave busy=0 immediately.
REQ-033 SHALL accept no write or clr on the first rising edge while rst=0; normal operation resumes on the first edge after rst returns to 1.

Verification (N=5, W=8, NR=2, BYPASS=1, ZERO_REG=1)
REQ-034 SHALL cover: write mem[i] = random for i=1..31, then read 10 random address pairs -> every rs matches the reference model; address 0 -> 0.
REQ-035 SHALL cover: we=1, addr_rd=7, data_in=0xA5 with addr_rs port0=7 in the same cycle -> rs port0=0xA5 before the edge; after the edge, mem[7]=0xA5.
REQ-036 SHALL cover: we=1, addr_rd=0, data_in=0xFF -> reads of address 0 return 0 and wr_drop stays 0.
REQ-037 SHALL cover: a one-cycle clr pulse -> busy high for exactly 32 cycles; afterwards all 32 registers read 0.
REQ-038 SHALL cover: we=1, addr_rd=3 issued at sweep cycle 10 -> write discarded, wr_drop pulses once, mem[3]=0 after the sweep ends.
REQ-039 SHALL cover: rst=0 asserted at sweep cycle 5 -> busy=0 immediately, all registers 0, and a write on the first edge after reset release succeeds.
